// File: rtl/alu_if.sv
// Operand/result bundle between the issue logic (master) and the execute-stage ALU (slave).
interface alu_if #(
  parameter int BW = 16
);
  logic [BW-1:0] in_a;
  logic [BW-1:0] in_b;
  logic [3:0]    opcode;
  logic [BW-1:0] out;
  logic [2:0]    flags;

  modport master (output in_a, output in_b, output opcode, input out, input flags);
  modport slave  (input in_a, input in_b, input opcode, output out, output flags);
endinterface

// File: rtl/alu.sv
// Registered BW-bit execute-stage ALU: result and {overflow, negative, zero} flags, one-cycle latency.
// Optional shift opcodes (SHL/SHR/ASR on 1000-1010) are built only when ALU_SHIFT_EN is defined.
module alu #(
  parameter int BW = 16
) (
  input  logic clk,
  input  logic rst_n,
  alu_if.slave bus
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_MOVA = 4'b0110;
  localparam logic [3:0] OP_MOVB = 4'b0111;
`ifdef ALU_SHIFT_EN
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_ASR  = 4'b1010;
  localparam int         SW      = $clog2(BW);
`endif

  localparam logic [BW-1:0] ONE_V     = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0] MAX_POS_V = {1'b0, {(BW-1){1'b1}}};

  logic [BW-1:0] a;
  logic [BW-1:0] b;
  logic [BW-1:0] result;
  logic          ovf;
  logic [2:0]    flags_next;

  assign a = bus.in_a;
  assign b = bus.in_b;

`ifdef ALU_SHIFT_EN
  logic [SW-1:0] amt;
  assign amt = b[SW-1:0];
`endif

  // Unimplemented opcodes fall to the default: result 0, so flags come out as 001.
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (bus.opcode)
      OP_ADD: begin
        result = a + b;
        ovf    = (a[BW-1] == b[BW-1]) && (result[BW-1] != a[BW-1]);
      end
      OP_SUB: begin
        result = a - b;
        ovf    = (a[BW-1] != b[BW-1]) && (result[BW-1] != a[BW-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_INC: begin
        result = a + ONE_V;
        ovf    = (a == MAX_POS_V);
      end
      OP_MOVA: result = a;
      OP_MOVB: result = b;
`ifdef ALU_SHIFT_EN
      OP_SHL:  result = a << amt;
      OP_SHR:  result = a >> amt;
      OP_ASR:  result = $unsigned($signed(a) >>> amt);
`endif
      default: result = '0;
    endcase
  end

  assign flags_next = {ovf, result[BW-1], (result == '0)};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out   <= '0;
      bus.flags <= 3'b000;
    end else begin
      bus.out   <= result;
      bus.flags <= flags_next;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors from the datasheet table plus random ops against an arithmetic model.
module tb_alu;

  localparam int BW = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_if #(.BW(BW)) bus ();

  alu #(.BW(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: signed/unsigned integer arithmetic on 64-bit values, truncated to BW bits.
  function automatic logic [BW+2:0] model(input logic [3:0] op, input logic [BW-1:0] a,
                                          input logic [BW-1:0] b);
    longint sa, sb, ua, ub, v, lo, hi, d;
    bit ovf;
    logic [BW-1:0] r;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'(a);
    ub  = longint'(b);
    lo  = -(longint'(1) <<< (BW-1));
    hi  = (longint'(1) <<< (BW-1)) - 1;
    d   = longint'(1) <<< (ub % BW);
    ovf = 1'b0;
    v   = 0;
    case (op)
      4'd0: begin v = sa + sb; ovf = (v > hi) || (v < lo); end
      4'd1: begin v = sa - sb; ovf = (v > hi) || (v < lo); end
      4'd2: v = ua & ub;
      4'd3: v = ua | ub;
      4'd4: v = ua ^ ub;
      4'd5: begin v = sa + 1; ovf = (v > hi); end
      4'd6: v = ua;
      4'd7: v = ub;
`ifdef ALU_SHIFT_EN
      4'd8: v = ua * d;
      4'd9: v = ua / d;
      4'd10: v = (sa >= 0) ? sa / d : -((-sa + d - 1) / d);
`endif
      default: v = 0;
    endcase
    r = v[BW-1:0];
    return {ovf, r[BW-1], (r == '0), r};
  endfunction

  task automatic check(input string tag, input logic [BW-1:0] exp_out, input logic [2:0] exp_flags);
    checks++;
    assert (bus.out === exp_out) else begin
      failures++;
      $error("FAIL %s out: got %h expected %h", tag, bus.out, exp_out);
    end
    checks++;
    assert (bus.flags === exp_flags) else begin
      failures++;
      $error("FAIL %s flags: got %b expected %b", tag, bus.flags, exp_flags);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] op, input logic [BW-1:0] a,
                      input logic [BW-1:0] b, input logic [BW-1:0] exp_out,
                      input logic [2:0] exp_flags);
    @(negedge clk);
    bus.opcode = op;
    bus.in_a   = a;
    bus.in_b   = b;
    @(posedge clk);
    #1;
    check(tag, exp_out, exp_flags);
  endtask

  task automatic step_model(input string tag, input logic [3:0] op, input logic [BW-1:0] a,
                            input logic [BW-1:0] b);
    logic [BW+2:0] m;
    m = model(op, a, b);
    step(tag, op, a, b, m[BW-1:0], m[BW+2:BW]);
  endtask

  function automatic logic [BW-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return BW'($urandom);
    endcase
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    rst_n     = 1'b0;
    bus.opcode = 4'($urandom);
    bus.in_a   = BW'($urandom);
    bus.in_b   = BW'($urandom);

    // Reset with random inputs for two cycles
    repeat (2) begin
      @(negedge clk);
      bus.opcode = 4'($urandom);
      bus.in_a   = BW'($urandom);
      bus.in_b   = BW'($urandom);
      @(posedge clk);
      #1;
      check("reset", 16'h0000, 3'b000);
    end
    @(negedge clk);
    rst_n = 1'b1;

    step("add_2_2",     4'b0000, 16'h0002, 16'h0002, 16'h0004, 3'b000);
    step("add_ffff",    4'b0000, 16'hFFFF, 16'hFFFF, 16'hFFFE, 3'b010);
    step("add_ovf",     4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 3'b110);
    step("sub_5_3",     4'b0001, 16'h0005, 16'h0003, 16'h0002, 3'b000);
    step("sub_2_3",     4'b0001, 16'h0002, 16'h0003, 16'hFFFF, 3'b010);
    step("sub_zero",    4'b0001, 16'h000F, 16'h000F, 16'h0000, 3'b001);
    step("sub_ovf1",    4'b0001, 16'h7FFF, 16'hFFFF, 16'h8000, 3'b110);
    step("sub_ovf2",    4'b0001, 16'h7FFF, 16'h8000, 16'hFFFF, 3'b110);
    step("and",         4'b0010, 16'hF0F0, 16'hFF00, 16'hF000, 3'b010);
    step("or",          4'b0011, 16'hF0F0, 16'hFF00, 16'hFFF0, 3'b010);
    step("xor",         4'b0100, 16'hF0F0, 16'hFF00, 16'h0FF0, 3'b000);
    step("inc_max",     4'b0101, 16'h7FFF, 16'hFF00, 16'h8000, 3'b110);
    step("inc_ffff",    4'b0101, 16'hFFFF, 16'h0000, 16'h0000, 3'b001);
    step("mova",        4'b0110, 16'hF0F0, 16'hFF00, 16'hF0F0, 3'b010);
    step("movb",        4'b0111, 16'hF0F0, 16'hFF00, 16'hFF00, 3'b010);
`ifdef ALU_SHIFT_EN
    step("shr_cfg",     4'b1001, 16'h8000, 16'h0004, 16'h0800, 3'b000);
    step("asr_cfg",     4'b1010, 16'h8000, 16'h0004, 16'hF800, 3'b010);
    step("shl_cfg",     4'b1000, 16'h8001, 16'h0001, 16'h0002, 3'b000);
`else
    step("shr_cfg",     4'b1001, 16'h8000, 16'h0004, 16'h0000, 3'b001);
    step("asr_cfg",     4'b1010, 16'h8000, 16'h0004, 16'h0000, 3'b001);
    step("shl_cfg",     4'b1000, 16'h8001, 16'h0001, 16'h0000, 3'b001);
`endif
    step("rsvd_1111",   4'b1111, 16'hFFFF, 16'hFFFF, 16'h0000, 3'b001);

    // Reset in mid-stream drops the in-flight result
    @(negedge clk);
    bus.opcode = 4'b0110;
    bus.in_a   = 16'h1234;
    rst_n      = 1'b0;
    @(posedge clk);
    #1;
    check("mid_reset", 16'h0000, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    step("after_reset", 4'b0110, 16'h1234, 16'h0000, 16'h1234, 3'b000);

    // Back-to-back random ops, one result checked per cycle
    for (int i = 0; i < 300; i++) begin
      step_model("rand", 4'($urandom_range(0, 15)), rand_operand(), rand_operand());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout: simulation did not complete, required completion before 100000");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
